lfsr_prng: RTL and testbench

LFSR_PRNG -- requirements
Module: lfsr_prng

---
 rtl/lfsr_pkg.sv | 42 ++++
 rtl/lfsr_step.sv | 22 ++
 rtl/lfsr_prng.sv | 117 +++++++++++
 tb/tb_lfsr_prng.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: tap masks per width, FSM state encoding and the
// single-shift next-state function used by every LFSR stage.
package lfsr_pkg;

  localparam logic [63:0] TAPS_W8  = 64'h0000_0000_0000_001D;
  localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_002D;
  localparam logic [63:0] TAPS_W32 = 64'h0000_0000_C000_0401;
  localparam logic [63:0] TAPS_W64 = 64'h0000_0000_0000_001B;

  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    ST_WARM  = 1'b0,
    ST_READY = 1'b1
  } lfsr_state_e;

  function automatic logic [63:0] tap_mask(input int unsigned width);
    case (width)
      32'd8:   return TAPS_W8;
      32'd16:  return TAPS_W16;
      32'd32:  return TAPS_W32;
      32'd64:  return TAPS_W64;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit width_supported(input int unsigned width);
    return (width == 32'd8) || (width == 32'd16) ||
           (width == 32'd32) || (width == 32'd64);
  endfunction

  // One Fibonacci shift: feedback enters at the MSB; state must be
  // zero-extended from `width` bits.
  function automatic logic [63:0] lfsr_shift(input logic [63:0] state,
                                             input int unsigned width);
    logic [63:0] nxt;
    nxt = state >> 1;
    nxt[6'(width - 32'd1)] = ^(state & tap_mask(width));
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational block applying N chained LFSR shifts to a WIDTH-bit state.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] acc_s;

  always_comb begin
    acc_s = state_i;
    for (int i = 0; i < N; i++) begin
      acc_s = WIDTH'(lfsr_shift(64'(acc_s), WIDTH));
    end
    state_o = acc_s;
  end

endmodule

// File: rtl/lfsr_prng.sv
// Maximal-length LFSR pseudo-random generator with warm-up phase, seed load,
// valid/ready output handshake and output range masking.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               STEP         = 1,
  parameter int               WARMUP       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed_load,
  input  logic [WIDTH-1:0]             seed,
  input  logic [$clog2(WIDTH+1)-1:0]   range_bits,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready
);

  if (!width_supported(WIDTH)) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be 8, 16, 32 or 64");
  end
  if ((STEP < 1) || (STEP > WIDTH)) begin : g_bad_step
    $error("lfsr_prng: STEP must lie in 1..WIDTH");
  end
  if ((WARMUP < 0) || (WARMUP > 255)) begin : g_bad_warmup
    $error("lfsr_prng: WARMUP must lie in 0..255");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: DEFAULT_SEED must be nonzero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] step1_s, stepn_s, mask_s, seed_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lfsr_state_e      fsm_q, fsm_d;
  logic             valid_q;

  lfsr_step #(.WIDTH(WIDTH), .N(1)) u_step_warm (
    .state_i (state_q),
    .state_o (step1_s)
  );

  lfsr_step #(.WIDTH(WIDTH), .N(STEP)) u_step_xfer (
    .state_i (state_q),
    .state_o (stepn_s)
  );

  // A zero seed would lock the LFSR, so it is replaced by all-ones.
  assign seed_s = (seed == '0) ? '1 : seed;

  // Next-state: seed load beats any transfer; warm-up shifts once per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsm_d   = fsm_q;
    if (seed_load) begin
      state_d = seed_s;
      cnt_d   = '0;
      fsm_d   = ST_WARM;
    end else begin
      case (fsm_q)
        ST_WARM: begin
          if (WARMUP == 0) begin
            fsm_d = ST_READY;
          end else begin
            state_d = step1_s;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_d == 8'(WARMUP)) begin
              fsm_d = ST_READY;
            end else begin
              fsm_d = ST_WARM;
            end
          end
        end
        ST_READY: begin
          if (dout_ready) begin
            state_d = stepn_s;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          fsm_d = ST_WARM;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEFAULT_SEED;
      cnt_q   <= '0;
      fsm_q   <= ST_WARM;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fsm_q   <= fsm_d;
      valid_q <= (fsm_d == ST_READY);
    end
  end

  // Keep the low range_bits bits; values above WIDTH naturally saturate.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_s[i] = (32'(range_bits) > 32'(i));
    end
  end

  assign dout       = state_q & mask_s;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed self-checking bench for lfsr_prng across several parameter sets.
module tb_lfsr_prng;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       sl8 = 1'b0, rdy8 = 1'b0, v8;
  logic [7:0] seed8 = 8'h00, dout8;
  logic [3:0] rb8 = 4'd8;

  logic        sla = 1'b0, rdya = 1'b0, va;
  logic [15:0] seeda = 16'h0000, douta;
  logic [4:0]  rba = 5'd16;

  logic        slb = 1'b0, rdyb = 1'b0, vb;
  logic [15:0] seedb = 16'h0000, doutb;
  logic [4:0]  rbb = 5'd16;

  logic        slw = 1'b0, rdyw = 1'b0, vw;
  logic [15:0] seedw = 16'h0000, doutw;
  logic [4:0]  rbw = 5'd16;

  lfsr_prng #(.WIDTH(8), .STEP(1), .WARMUP(0)) u8 (
    .clk(clk), .rst(rst), .seed_load(sl8), .seed(seed8), .range_bits(rb8),
    .dout(dout8), .dout_valid(v8), .dout_ready(rdy8));

  lfsr_prng #(.WIDTH(16), .STEP(4), .WARMUP(0)) ua (
    .clk(clk), .rst(rst), .seed_load(sla), .seed(seeda), .range_bits(rba),
    .dout(douta), .dout_valid(va), .dout_ready(rdya));

  lfsr_prng #(.WIDTH(16), .STEP(1), .WARMUP(0)) ub (
    .clk(clk), .rst(rst), .seed_load(slb), .seed(seedb), .range_bits(rbb),
    .dout(doutb), .dout_valid(vb), .dout_ready(rdyb));

  lfsr_prng #(.WIDTH(16)) uw (
    .clk(clk), .rst(rst), .seed_load(slw), .seed(seedw), .range_bits(rbw),
    .dout(doutw), .dout_valid(vw), .dout_ready(rdyw));

  function automatic logic [7:0] m8(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  function automatic logic [15:0] m16(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] m16n(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = m16(r);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ha [40];
  logic [15:0] hb [40];
  logic [15:0] first_w, second_w, full_w;
  logic [7:0]  m8s;
  int          lowcnt, bad, mism;
  bit          zero_seen, early, gap, stable;

  initial begin
    tick();
    tick();
    check_eq("rst_valid8", v8, 1'b0);
    check_eq("rst_validw", vw, 1'b0);
    check_eq("rst_doutw", doutw, 16'hFFFF);
    rst = 1'b0;

    // 8-bit full period from seed 0x01
    sl8 = 1'b1; seed8 = 8'h01; rb8 = 4'd8; rdy8 = 1'b1;
    tick();
    sl8 = 1'b0;
    check_eq("u8_warm_after_load", v8, 1'b0);
    for (int i = 0; i < 20 && !v8; i++) tick();
    check_eq("u8_valid", v8, 1'b1);
    check_eq("u8_first", dout8, 8'h01);
    tick();
    check_eq("u8_second", dout8, 8'h80);
    zero_seen = 1'b0; early = 1'b0; gap = 1'b0; mism = 0; m8s = 8'h80;
    for (int k = 2; k <= 255; k++) begin
      tick();
      m8s = m8(m8s);
      if (dout8 == 8'h00) zero_seen = 1'b1;
      if (dout8 == 8'h01 && k != 255) early = 1'b1;
      if (dout8 != m8s) mism++;
      if (!v8) gap = 1'b1;
    end
    check_eq("u8_period_wrap", dout8, 8'h01);
    check_eq("u8_no_zero", zero_seen, 1'b0);
    check_eq("u8_no_early_repeat", early, 1'b0);
    check_eq("u8_model_mism", mism, 0);
    check_eq("u8_no_bubble", gap, 1'b0);
    rdy8 = 1'b0;

    // zero seed becomes all-ones, then stall behaviour
    slb = 1'b1; seedb = 16'h0000; rdyb = 1'b0;
    tick();
    slb = 1'b0;
    for (int i = 0; i < 20 && !vb; i++) tick();
    check_eq("ub_valid", vb, 1'b1);
    check_eq("ub_zero_seed", doutb, 16'hFFFF);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (doutb != 16'hFFFF || !vb) stable = 1'b0;
    end
    check_eq("ub_stall_stable", stable, 1'b1);
    rdyb = 1'b1;
    tick();
    check_eq("ub_after_stall1", doutb, 16'h7FFF);
    tick();
    check_eq("ub_after_stall2", doutb, 16'h3FFF);

    // seed load coinciding with a transfer
    slb = 1'b1; seedb = 16'h00A5;
    check_eq("ub_old_dout_on_xfer", doutb, 16'h3FFF);
    tick();
    slb = 1'b0;
    check_eq("ub_load_drops_valid", vb, 1'b0);
    for (int i = 0; i < 20 && !vb; i++) tick();
    check_eq("ub_load_wins", doutb, 16'h00A5);

    // STEP=4 vs STEP=1 from 0xACE1
    sla = 1'b1; slb = 1'b1; seeda = 16'hACE1; seedb = 16'hACE1;
    rdya = 1'b1; rdyb = 1'b1;
    tick();
    sla = 1'b0; slb = 1'b0;
    for (int i = 0; i < 20 && !(va && vb); i++) tick();
    check_eq("ab_valid", va & vb, 1'b1);
    gap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ha[k] = douta;
      hb[k] = doutb;
      if (!va) gap = 1'b1;
      tick();
    end
    check_eq("ab_a0", ha[0], 16'hACE1);
    check_eq("ab_b1", hb[1], 16'h5670);
    check_eq("ab_a1_model", ha[1], m16n(16'hACE1, 4));
    check_eq("ab_a5_model", ha[5], m16n(16'hACE1, 20));
    for (int k = 0; k < 10; k++) check_eq("ab_a_vs_b4", ha[k], hb[4*k]);
    check_eq("a_no_bubble", gap, 1'b0);
    rdya = 1'b0; rdyb = 1'b0;

    // warm-up after reset
    rdyw = 1'b0; rbw = 5'd16;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lowcnt = 0;
    while (!vw && lowcnt < 100) begin
      lowcnt++;
      tick();
    end
    check_eq("w_warm_cycles", lowcnt, 16);
    first_w = m16n(16'hFFFF, 16);
    check_eq("w_first", doutw, first_w);
    rdyw = 1'b1;
    tick();
    second_w = m16(first_w);
    check_eq("w_second", doutw, second_w);
    for (int i = 0; i < 5; i++) tick();

    // mid-stream reset replays the sequence; reset overrides handshake/load
    rst = 1'b1; slw = 1'b1; seedw = 16'h5555;
    tick();
    rst = 1'b0; slw = 1'b0;
    lowcnt = 0;
    while (!vw && lowcnt < 100) begin
      lowcnt++;
      tick();
    end
    check_eq("w_rereset_cycles", lowcnt, 16);
    check_eq("w_rereset_first", doutw, first_w);
    tick();
    check_eq("w_rereset_second", doutw, second_w);

    // seed load in the middle of READY
    slw = 1'b1; seedw = 16'h1234;
    tick();
    slw = 1'b0;
    lowcnt = 0;
    while (!vw && lowcnt < 100) begin
      lowcnt++;
      tick();
    end
    check_eq("w_reload_cycles", lowcnt, 16);
    check_eq("w_reload_first", doutw, m16n(16'h1234, 16));

    // range masking
    rbw = 5'd3; bad = 0;
    for (int i = 0; i < 60; i++) begin
      rdyw = 1'($urandom_range(0, 1));
      tick();
      if (doutw >= 16'd8) bad++;
    end
    check_eq("w_range3", bad, 0);
    rdyw = 1'b0;
    tick();
    rbw = 5'd0;
    #1;
    check_eq("w_range0", doutw, 16'h0000);
    rbw = 5'd16;
    #1;
    full_w = doutw;
    rbw = 5'd31;
    #1;
    check_eq("w_range_sat", doutw, full_w);
    rbw = 5'd5;
    #1;
    check_eq("w_range5", doutw, full_w & 16'h001F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
